map_tile_reader: RTL and testbench

- Consumer side of the game-state map interface. Takes the five 144-bit 12x12 occupancy maps from the game hub.
- Snapshots the maps once per frame so a frame never shows a half-updated board.
- Translates each VGA pixel coordinate into board row/column, in-tile offsets and a prioritised tile type for the sprite/colour mapper.
- Fixed 2-cycle pipeline, one pixel per clock.

---
 rtl/map_tile_reader_if.sv | 36 +++
 rtl/map_tile_reader.sv | 163 ++++++++++++++++
 tb/tb_map_tile_reader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/map_tile_reader_if.sv
// Map/pixel bundle between the game hub, the VGA scan and the tile reader.
// The master drives maps and pixel coordinates; the slave returns tile info.
interface map_tile_reader_if #(
    parameter int GRID = 12
);
    logic                   Frame_Start;
    logic [GRID*GRID-1:0]   Wall_Map;
    logic [GRID*GRID-1:0]   Flame_Map;
    logic [GRID*GRID-1:0]   Bomb_Map;
    logic [GRID*GRID-1:0]   Tree_Map;
    logic [GRID*GRID-1:0]   Treasure_Map;
    logic                   Pix_Valid;
    logic [9:0]             DrawX;
    logic [9:0]             DrawY;
    logic                   Tile_Valid;
    logic [2:0]             Tile_Type;
    logic [3:0]             Tile_Row;
    logic [3:0]             Tile_Col;
    logic [5:0]             Tile_Off_X;
    logic [5:0]             Tile_Off_Y;
    logic [7:0]             Snap_Count;

    modport master (
        output Frame_Start, Wall_Map, Flame_Map, Bomb_Map, Tree_Map, Treasure_Map,
        output Pix_Valid, DrawX, DrawY,
        input  Tile_Valid, Tile_Type, Tile_Row, Tile_Col, Tile_Off_X, Tile_Off_Y,
        input  Snap_Count
    );

    modport slave (
        input  Frame_Start, Wall_Map, Flame_Map, Bomb_Map, Tree_Map, Treasure_Map,
        input  Pix_Valid, DrawX, DrawY,
        output Tile_Valid, Tile_Type, Tile_Row, Tile_Col, Tile_Off_X, Tile_Off_Y,
        output Snap_Count
    );
endinterface

// File: rtl/map_tile_reader.sv
// Per-frame map snapshot plus a 2-stage pixel-to-tile pipeline: stage 1 splits
// the pixel into row/column/offset, stage 2 looks up and prioritises the tile.
module map_tile_reader #(
    parameter int GRID     = 12,
    parameter int TILE     = 40,
    parameter int X_OFFSET = 80,
    parameter int Y_OFFSET = 0
) (
    input logic             Clk,
    input logic             Reset,
    map_tile_reader_if.slave bus
);
    localparam int MAP_BITS = GRID * GRID;
    localparam int SPAN     = GRID * TILE;

    localparam logic [2:0] TYPE_EMPTY    = 3'd0;
    localparam logic [2:0] TYPE_WALL     = 3'd1;
    localparam logic [2:0] TYPE_TREE     = 3'd2;
    localparam logic [2:0] TYPE_TREASURE = 3'd3;
    localparam logic [2:0] TYPE_BOMB     = 3'd4;
    localparam logic [2:0] TYPE_FLAME    = 3'd5;
    localparam logic [2:0] TYPE_OFF      = 3'd7;

    // Compare/subtract chain: {tile index, offset}; the last multiple of TILE
    // not exceeding v wins, so no divider is needed.
    function automatic logic [9:0] split_tile(input logic [9:0] v);
        logic [3:0] idx;
        logic [5:0] off;
        idx = 4'd0;
        off = v[5:0];
        for (int i = 1; i < GRID; i++) begin
            if (v >= 10'(i * TILE)) begin
                idx = 4'(i);
                off = 6'(v - 10'(i * TILE));
            end else begin
                idx = idx;
            end
        end
        return {idx, off};
    endfunction

    logic [MAP_BITS-1:0] wall_sh_r, flame_sh_r, bomb_sh_r, tree_sh_r, treasure_sh_r;
    logic [7:0]          snap_count_r;

    logic [10:0] x_diff_s, y_diff_s;
    logic [9:0]  x_split_s, y_split_s;
    logic        off_board_s;

    logic       s1_valid_r, s1_off_board_r;
    logic [3:0] s1_row_r, s1_col_r;
    logic [5:0] s1_off_x_r, s1_off_y_r;

    logic [7:0] bit_idx_s;
    logic [2:0] type_s;

    logic       tile_valid_r;
    logic [2:0] tile_type_r;
    logic [3:0] tile_row_r, tile_col_r;
    logic [5:0] tile_off_x_r, tile_off_y_r;

    // A borrow out of the 11-bit subtraction marks a pixel left of/above the board.
    assign x_diff_s    = {1'b0, bus.DrawX} - 11'(X_OFFSET);
    assign y_diff_s    = {1'b0, bus.DrawY} - 11'(Y_OFFSET);
    assign off_board_s = x_diff_s[10] | y_diff_s[10]
                       | (x_diff_s[9:0] >= 10'(SPAN)) | (y_diff_s[9:0] >= 10'(SPAN));
    assign x_split_s   = split_tile(x_diff_s[9:0]);
    assign y_split_s   = split_tile(y_diff_s[9:0]);

    // Shadow maps and snapshot counter, reloaded only on Frame_Start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wall_sh_r     <= '0;
            flame_sh_r    <= '0;
            bomb_sh_r     <= '0;
            tree_sh_r     <= '0;
            treasure_sh_r <= '0;
            snap_count_r  <= 8'd0;
        end else if (bus.Frame_Start) begin
            wall_sh_r     <= bus.Wall_Map;
            flame_sh_r    <= bus.Flame_Map;
            bomb_sh_r     <= bus.Bomb_Map;
            tree_sh_r     <= bus.Tree_Map;
            treasure_sh_r <= bus.Treasure_Map;
            snap_count_r  <= snap_count_r + 8'd1;
        end else begin
            snap_count_r  <= snap_count_r;
        end
    end

    // Stage 1: coordinate split and off-board flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_r     <= 1'b0;
            s1_off_board_r <= 1'b0;
            s1_row_r       <= 4'd0;
            s1_col_r       <= 4'd0;
            s1_off_x_r     <= 6'd0;
            s1_off_y_r     <= 6'd0;
        end else begin
            s1_valid_r     <= bus.Pix_Valid;
            s1_off_board_r <= off_board_s;
            s1_row_r       <= y_split_s[9:6];
            s1_col_r       <= x_split_s[9:6];
            s1_off_x_r     <= x_split_s[5:0];
            s1_off_y_r     <= y_split_s[5:0];
        end
    end

    // Row 0 / column 0 sit at the MSB; row and column never exceed GRID-1.
    assign bit_idx_s = 8'(MAP_BITS - 1) - 8'(int'(s1_row_r) * GRID + int'(s1_col_r));

    // Tile priority: wall > flame > bomb > tree > treasure > empty.
    always_comb begin
        type_s = TYPE_EMPTY;
        if (wall_sh_r[bit_idx_s]) begin
            type_s = TYPE_WALL;
        end else if (flame_sh_r[bit_idx_s]) begin
            type_s = TYPE_FLAME;
        end else if (bomb_sh_r[bit_idx_s]) begin
            type_s = TYPE_BOMB;
        end else if (tree_sh_r[bit_idx_s]) begin
            type_s = TYPE_TREE;
        end else if (treasure_sh_r[bit_idx_s]) begin
            type_s = TYPE_TREASURE;
        end else begin
            type_s = TYPE_EMPTY;
        end
    end

    // Stage 2: registered outputs; off-board pixels report type 7 and zeros.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tile_valid_r <= 1'b0;
            tile_type_r  <= TYPE_EMPTY;
            tile_row_r   <= 4'd0;
            tile_col_r   <= 4'd0;
            tile_off_x_r <= 6'd0;
            tile_off_y_r <= 6'd0;
        end else if (s1_off_board_r) begin
            tile_valid_r <= s1_valid_r;
            tile_type_r  <= TYPE_OFF;
            tile_row_r   <= 4'd0;
            tile_col_r   <= 4'd0;
            tile_off_x_r <= 6'd0;
            tile_off_y_r <= 6'd0;
        end else begin
            tile_valid_r <= s1_valid_r;
            tile_type_r  <= type_s;
            tile_row_r   <= s1_row_r;
            tile_col_r   <= s1_col_r;
            tile_off_x_r <= s1_off_x_r;
            tile_off_y_r <= s1_off_y_r;
        end
    end

    assign bus.Tile_Valid = tile_valid_r;
    assign bus.Tile_Type  = tile_type_r;
    assign bus.Tile_Row   = tile_row_r;
    assign bus.Tile_Col   = tile_col_r;
    assign bus.Tile_Off_X = tile_off_x_r;
    assign bus.Tile_Off_Y = tile_off_y_r;
    assign bus.Snap_Count = snap_count_r;
endmodule

// File: tb/tb_map_tile_reader.sv
// Directed bench for map_tile_reader: vector table for the coordinate split,
// hand sequences for snapshot timing, streaming, reset and counter wrap.
module tb_map_tile_reader;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   passed = 0;
    int   total = 0;
    int   exp_snap = 0;

    map_tile_reader_if #(.GRID(12)) bus ();

    map_tile_reader dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] typ;
        logic [3:0] row;
        logic [3:0] col;
        logic [5:0] ox;
        logic [5:0] oy;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic snapshot();
        bus.Frame_Start = 1'b1;
        step();
        bus.Frame_Start = 1'b0;
        exp_snap = (exp_snap + 1) % 256;
    endtask

    // Issue one pixel, wait the two pipeline stages, compare every field.
    task automatic run_pixel(input string name, input vec_t v);
        bus.DrawX     = v.x;
        bus.DrawY     = v.y;
        bus.Pix_Valid = 1'b1;
        step();
        bus.Pix_Valid = 1'b0;
        step();
        check({name, ".valid"}, 32'(bus.Tile_Valid), 32'd1);
        check({name, ".type"},  32'(bus.Tile_Type),  32'(v.typ));
        check({name, ".row"},   32'(bus.Tile_Row),   32'(v.row));
        check({name, ".col"},   32'(bus.Tile_Col),   32'(v.col));
        check({name, ".offx"},  32'(bus.Tile_Off_X), 32'(v.ox));
        check({name, ".offy"},  32'(bus.Tile_Off_Y), 32'(v.oy));
    endtask

    function automatic vec_t mk(input int x, input int y, input int t, input int r,
                                input int c, input int ox, input int oy);
        vec_t v;
        v.x = 10'(x); v.y = 10'(y); v.typ = 3'(t);
        v.row = 4'(r); v.col = 4'(c); v.ox = 6'(ox); v.oy = 6'(oy);
        return v;
    endfunction

    initial begin
        bus.Frame_Start  = 1'b0;
        bus.Wall_Map     = 144'd0;
        bus.Flame_Map    = 144'd0;
        bus.Bomb_Map     = 144'd0;
        bus.Tree_Map     = 144'd0;
        bus.Treasure_Map = 144'd0;
        bus.Pix_Valid    = 1'b0;
        bus.DrawX        = 10'd0;
        bus.DrawY        = 10'd0;

        // Vectors evaluated against a snapshot with only row 0 of Wall set.
        vecs[0] = mk(80,   0,   1, 0,  0,  0,  0);
        vecs[1] = mk(559,  0,   1, 0,  11, 39, 0);
        vecs[2] = mk(120,  40,  0, 1,  1,  0,  0);
        vecs[3] = mk(559,  479, 0, 11, 11, 39, 39);
        vecs[4] = mk(560,  479, 7, 0,  0,  0,  0);
        vecs[5] = mk(79,   0,   7, 0,  0,  0,  0);
        vecs[6] = mk(80,   480, 7, 0,  0,  0,  0);
        vecs[7] = mk(1023, 1023,7, 0,  0,  0,  0);
        vecs[8] = mk(333,  217, 0, 5,  6,  13, 17);

        step();
        step();
        check("reset.valid", 32'(bus.Tile_Valid), 32'd0);
        check("reset.type",  32'(bus.Tile_Type),  32'd0);
        check("reset.snap",  32'(bus.Snap_Count), 32'd0);
        Reset = 1'b0;

        bus.Wall_Map = {12'hFFF, 132'd0};
        snapshot();
        check("snap.count1", 32'(bus.Snap_Count), 32'(exp_snap));
        for (int i = 0; i < 9; i++) begin
            run_pixel($sformatf("vec%0d", i), vecs[i]);
        end

        // Priority at row 1, col 1 (bit 130).
        bus.Wall_Map = 144'd0;
        bus.Wall_Map[130] = 1'b1;
        bus.Flame_Map[130] = 1'b1;
        bus.Treasure_Map[130] = 1'b1;
        snapshot();
        run_pixel("prio.wall", mk(125, 45, 1, 1, 1, 5, 5));
        bus.Wall_Map[130] = 1'b0;
        snapshot();
        run_pixel("prio.flame", mk(125, 45, 5, 1, 1, 5, 5));
        bus.Flame_Map[130] = 1'b0;
        snapshot();
        run_pixel("prio.treasure", mk(125, 45, 3, 1, 1, 5, 5));
        bus.Tree_Map[130] = 1'b1;
        snapshot();
        run_pixel("prio.tree", mk(125, 45, 2, 1, 1, 5, 5));

        // Row 2, col 2 (bit 117): map change invisible until snapshot.
        bus.Bomb_Map[117] = 1'b1;
        bus.Tree_Map[117] = 1'b1;
        run_pixel("nosnap", mk(165, 85, 0, 2, 2, 5, 5));
        snapshot();
        run_pixel("bomb", mk(165, 85, 4, 2, 2, 5, 5));
        check("snap.count2", 32'(bus.Snap_Count), 32'(exp_snap));

        // Stream 10 pixels; Frame_Start lands in pixel 1's stage-2 cycle.
        bus.Bomb_Map = 144'd0;
        bus.Tree_Map = 144'd0;
        bus.Treasure_Map = 144'd0;
        bus.Wall_Map = {12'hFFF, 132'd0};
        snapshot();
        bus.Wall_Map = 144'd0;
        for (int t = 0; t < 13; t++) begin
            bus.Pix_Valid   = (t < 10);
            bus.DrawX       = 10'(80 + t);
            bus.DrawY       = 10'd0;
            bus.Frame_Start = (t == 2);
            step();
            if (t >= 1 && t <= 10) begin
                check($sformatf("stream%0d.valid", t - 1), 32'(bus.Tile_Valid), 32'd1);
                check($sformatf("stream%0d.offx", t - 1), 32'(bus.Tile_Off_X), 32'(t - 1));
                check($sformatf("stream%0d.type", t - 1), 32'(bus.Tile_Type),
                      (t - 1 <= 1) ? 32'd1 : 32'd0);
            end else begin
                check($sformatf("stream.idle%0d", t), 32'(bus.Tile_Valid), 32'd0);
            end
        end
        bus.Frame_Start = 1'b0;
        bus.Pix_Valid = 1'b0;
        exp_snap = (exp_snap + 1) % 256;
        check("snap.count3", 32'(bus.Snap_Count), 32'(exp_snap));

        // Reset with pixels in flight.
        bus.Wall_Map = {12'hFFF, 132'd0};
        snapshot();
        bus.DrawX = 10'd80;
        bus.Pix_Valid = 1'b1;
        step();
        bus.DrawX = 10'd81;
        Reset = 1'b1;
        step();
        check("rst.valid", 32'(bus.Tile_Valid), 32'd0);
        check("rst.snap",  32'(bus.Snap_Count), 32'd0);
        exp_snap = 0;
        Reset = 1'b0;
        bus.Pix_Valid = 1'b0;
        step();
        check("rst.stale1", 32'(bus.Tile_Valid), 32'd0);
        step();
        check("rst.stale2", 32'(bus.Tile_Valid), 32'd0);
        run_pixel("rst.cleared", mk(80, 0, 0, 0, 0, 0, 0));

        // Counter wrap.
        for (int i = 0; i < 255; i++) begin
            snapshot();
            step();
        end
        check("wrap.255", 32'(bus.Snap_Count), 32'd255);
        snapshot();
        check("wrap.0", 32'(bus.Snap_Count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
